// File: rtl/multi_reg_file.sv
// Multi-port register file (3 combinational reads, 1 write, reg0 tied to zero)
// plus the program counter used by the single-cycle datapath.
module multi_reg_file #(
    parameter int unsigned ADDR = 4,
    parameter int unsigned NUMB = 1 << ADDR,
    parameter int unsigned SIZE = 32
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [4:0]      M,
    input  logic            Write_PC,
    input  logic [SIZE-1:0] PC_New,
    input  logic            Write_Reg,
    input  logic [ADDR-1:0] R_Addr_A,
    input  logic [ADDR-1:0] R_Addr_B,
    input  logic [ADDR-1:0] R_Addr_C,
    input  logic [ADDR-1:0] W_Addr,
    input  logic [SIZE-1:0] W_Data,
    output logic [SIZE-1:0] R_Data_A,
    output logic [SIZE-1:0] R_Data_B,
    output logic [SIZE-1:0] R_Data_C,
    output logic [SIZE-1:0] PC
);

    localparam logic [3:0] PC_LOAD = 4'h0;
    localparam logic [3:0] PC_SEQ  = 4'h1;
    localparam logic [3:0] PC_REL  = 4'h2;
    localparam logic [3:0] PC_WREL = 4'h3;

    logic [SIZE-1:0] regs [NUMB];
    logic            reg_we;

    assign reg_we = Write_Reg && M[4] && (W_Addr != '0);

    // Register array; address 0 is never written so it stays at its reset value
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < NUMB; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[W_Addr] <= W_Data;
        end
    end

    // Combinational reads, no bypass from the write port
    assign R_Data_A = (R_Addr_A == '0) ? '0 : regs[R_Addr_A];
    assign R_Data_B = (R_Addr_B == '0) ? '0 : regs[R_Addr_B];
    assign R_Data_C = (R_Addr_C == '0) ? '0 : regs[R_Addr_C];

    // Program counter; all arithmetic wraps modulo 2^SIZE
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            PC <= '0;
        end else if (Write_PC) begin
            case (M[3:0])
                PC_LOAD: PC <= PC_New;
                PC_SEQ:  PC <= PC + SIZE'(4);
                PC_REL:  PC <= PC + PC_New;
                PC_WREL: PC <= PC + {PC_New[SIZE-3:0], 2'b00};
                default: PC <= PC;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_reg_file.sv
// Randomized self-checking bench for multi_reg_file against an array-based reference model.
module tb_multi_reg_file;

    localparam int unsigned ADDR = 4;
    localparam int unsigned NUMB = 16;
    localparam int unsigned SIZE = 32;

    logic            Clk = 1'b0;
    logic            Rst;
    logic [4:0]      M;
    logic            Write_PC;
    logic [SIZE-1:0] PC_New;
    logic            Write_Reg;
    logic [ADDR-1:0] R_Addr_A, R_Addr_B, R_Addr_C, W_Addr;
    logic [SIZE-1:0] W_Data;
    logic [SIZE-1:0] R_Data_A, R_Data_B, R_Data_C, PC;

    int n_checks = 0;
    int n_errors = 0;

    logic [SIZE-1:0] ref_mem [NUMB];
    logic [SIZE-1:0] ref_pc;

    multi_reg_file #(.ADDR(ADDR), .NUMB(NUMB), .SIZE(SIZE)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .M        (M),
        .Write_PC (Write_PC),
        .PC_New   (PC_New),
        .Write_Reg(Write_Reg),
        .R_Addr_A (R_Addr_A),
        .R_Addr_B (R_Addr_B),
        .R_Addr_C (R_Addr_C),
        .W_Addr   (W_Addr),
        .W_Data   (W_Data),
        .R_Data_A (R_Data_A),
        .R_Data_B (R_Data_B),
        .R_Data_C (R_Data_C),
        .PC       (PC)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [SIZE-1:0] ref_read(input logic [ADDR-1:0] a);
        return (a == 0) ? '0 : ref_mem[a];
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_a"},  R_Data_A, ref_read(R_Addr_A));
        check({tag, "_b"},  R_Data_B, ref_read(R_Addr_B));
        check({tag, "_c"},  R_Data_C, ref_read(R_Addr_C));
        check({tag, "_pc"}, PC, ref_pc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NUMB); i++) ref_mem[i] = '0;
        ref_pc = '0;
    endtask

    // Behaviour of one rising edge, computed from the current inputs
    task automatic model_edge();
        longint unsigned p, n;
        if (Write_Reg && M[4] && W_Addr != 0) ref_mem[W_Addr] = W_Data;
        if (Write_PC) begin
            p = longint'(ref_pc);
            n = longint'(PC_New);
            case (int'(M[3:0]))
                0: p = n;
                1: p = p + 4;
                2: p = p + n;
                3: p = p + n * 4;
                default: ;
            endcase
            ref_pc = p[SIZE-1:0];
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        Write_Reg = 1'b0; Write_PC = 1'b0; M = 5'h00; PC_New = '0;
        W_Addr = '0; W_Data = '0;
    endtask

    task automatic drive_random();
        M         = 5'($urandom_range(0, 31));
        M[3]      = ($urandom_range(0, 3) == 0);
        Write_PC  = 1'($urandom);
        Write_Reg = ($urandom_range(0, 3) != 0);
        PC_New    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
        W_Addr    = 4'($urandom);
        W_Data    = $urandom;
        R_Addr_A  = 4'($urandom);
        R_Addr_B  = ($urandom_range(0, 3) == 0) ? W_Addr : 4'($urandom);
        R_Addr_C  = ($urandom_range(0, 3) == 0) ? R_Addr_A : 4'($urandom);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset(input string tag);
        #2;
        Rst = 1'b0;
        #1;
        model_reset();
        check({tag, "_a"},  R_Data_A, '0);
        check({tag, "_b"},  R_Data_B, '0);
        check({tag, "_c"},  R_Data_C, '0);
        check({tag, "_pc"}, PC, '0);
        #1;
        Rst = 1'b1;
        #1;
    endtask

    initial begin
        Rst = 1'b0;
        idle();
        R_Addr_A = '0; R_Addr_B = '0; R_Addr_C = '0;
        model_reset();
        #2;
        check_all("reset");
        #10;
        Rst = 1'b1;
        tick();

        // Write to reg5 visible on all three ports
        M = 5'h10; Write_Reg = 1'b1; W_Addr = 4'd5; W_Data = 32'hDEAD_BEEF;
        R_Addr_A = 4'd5; R_Addr_B = 4'd5; R_Addr_C = 4'd5;
        #1;
        check("wr5_before", R_Data_A, 32'h0);
        tick();
        check("wr5_a", R_Data_A, 32'hDEAD_BEEF);
        check("wr5_b", R_Data_B, 32'hDEAD_BEEF);
        check("wr5_c", R_Data_C, 32'hDEAD_BEEF);

        // Masked write and write to reg0
        M = 5'h00; W_Data = 32'h1234_5678;
        tick();
        check("wr_no_m4", R_Data_A, 32'hDEAD_BEEF);
        M = 5'h10; W_Addr = 4'd0; R_Addr_B = 4'd0;
        tick();
        check("wr_reg0", R_Data_B, 32'h0);
        check("wr_reg0_r5", R_Data_A, 32'hDEAD_BEEF);

        // PC load then sequential increments
        idle();
        Write_PC = 1'b1; M = 5'h00; PC_New = 32'h100;
        tick();
        check("pc_load", PC, 32'h100);
        M = 5'h01;
        tick();
        check("pc_seq1", PC, 32'h104);
        tick();
        check("pc_seq2", PC, 32'h108);

        // Wrap and negative relative offset
        M = 5'h00; PC_New = 32'hFFFF_FFFC;
        tick();
        M = 5'h01;
        tick();
        check("pc_wrap", PC, 32'h0);
        M = 5'h00; PC_New = 32'h200;
        tick();
        M = 5'h02; PC_New = 32'hFFFF_FFF0;
        tick();
        check("pc_rel_neg", PC, 32'h1F0);

        // Unsupported mode and Write_PC low both hold PC
        M = 5'h07; PC_New = 32'h55;
        tick();
        check("pc_mode_hold", PC, 32'h1F0);
        Write_PC = 1'b0; M = 5'h00;
        tick();
        check("pc_nowrite", PC, 32'h1F0);

        // Reset held across an edge with writes requested
        Write_PC = 1'b1; Write_Reg = 1'b1; M = 5'h10; W_Addr = 4'd9; W_Data = 32'hA5A5_A5A5;
        PC_New = 32'h77; R_Addr_A = 4'd5; R_Addr_B = 4'd9;
        Rst = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        check("rst_edge_a", R_Data_A, 32'h0);
        check("rst_edge_b", R_Data_B, 32'h0);
        check("rst_edge_pc", PC, 32'h0);
        Rst = 1'b1;
        idle();

        // Same-edge register write and word-relative PC update
        M = 5'h10; Write_Reg = 1'b1; W_Addr = 4'd3; W_Data = 32'd5;
        Write_PC = 1'b1; PC_New = 32'h0;
        tick();
        W_Data = 32'd7; M = 5'h13; PC_New = 32'd2; R_Addr_A = 4'd3;
        #1;
        check("same_edge_old", R_Data_A, 32'd5);
        tick();
        check("same_edge_reg", R_Data_A, 32'd7);
        check("same_edge_pc", PC, 32'd8);

        // Random traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            drive_random();
            #1;
            check_all("rand_pre");
            tick();
            check_all("rand_post");
            if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
        end

        // Reset after arbitrary writes clears read ports without a clock
        idle();
        for (int r = 1; r < 4; r++) begin
            W_Addr = 4'(r); W_Data = 32'hC0DE_0000 | 32'(r); Write_Reg = 1'b1; M = 5'h10;
            Write_PC = 1'b1; PC_New = 32'h400;
            tick();
        end
        idle();
        R_Addr_A = 4'd1; R_Addr_B = 4'd2; R_Addr_C = 4'd3;
        #1;
        check_all("pre_final_rst");
        async_reset("final_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
